inst_encoder: RTL and testbench

Sequential instruction encoder: the writer-side counterpart of the control decoder. Accepts one symbolic instruction per cycle over a valid/ready handshake, packs it into the 9-bit machine word the decoder consumes, and writes consecutive words into instruction memory from address 0. On the last instruction it appends the 9'h1FF done (Ack) word and reports completion. Used by the bench and the boot loader to build programs without hand-assembling bit patterns.

---
 rtl/inst_encoder.sv | 195 +++++++++++++++++++
 tb/tb_inst_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Sequential instruction encoder: packs symbolic instructions into 9-bit machine
// words, writes them from address 0 upward and appends the 9'h1FF Ack terminator.
module inst_encoder #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InValid,
   output logic              InReady,
   input  logic [3:0]        Mnemonic,
   input  logic [3:0]        FieldA,
   input  logic [3:0]        FieldB,
   input  logic [4:0]        Imm,
   input  logic              Flag,
   input  logic              Last,
   output logic              WrEn,
   output logic [ADDR_W-1:0] WrAddr,
   output logic [8:0]        WrData,
   output logic              Done,
   output logic              Error,
   output logic [ADDR_W:0]   Count,
   output logic [1:0]        DbgState
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_TERM = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [8:0]        ACK_WORD       = 9'h1FF;
   localparam logic [ADDR_W-1:0] ADDR_ONE       = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE        = (ADDR_W + 1)'(1);
   // Highest address an instruction may use; the slot above belongs to the terminator.
   localparam logic [ADDR_W-1:0] LAST_DATA_ADDR = ADDR_W'(DEPTH - 2);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [8:0]          wr_data_q, wr_data_d;
   logic                done_q, done_d;
   logic                error_q, error_d;

   logic [8:0]          enc_word;
   logic                enc_illegal;
   logic                xfer;

   // Handshake: a transfer happens in any cycle where InValid && InReady;
   // InReady is a pure decode of the RUN state, so it never depends on InValid.
   assign InReady  = (state_q == ST_RUN);
   assign xfer     = InValid && InReady;

   assign WrEn     = wr_en_q;
   assign WrAddr   = wr_addr_q;
   assign WrData   = wr_data_q;
   assign Done     = done_q;
   assign Error    = error_q;
   assign Count    = count_q;
   assign DbgState = state_q;

   always_comb begin
      enc_word    = '0;
      enc_illegal = 1'b0;
      case (Mnemonic)
         4'd0: begin
            enc_word    = {3'b000, FieldA[2:0], FieldB[2:0]};
            enc_illegal = FieldA[3];
         end
         4'd1: begin
            enc_word    = {3'b001, FieldA[2:0], FieldB[2:0]};
            enc_illegal = FieldA[3];
         end
         4'd2: begin
            enc_word    = {4'b1101, FieldA[2:0], FieldB[1:0]};
            enc_illegal = FieldA[3] || (FieldB[3:2] != 2'b01);
         end
         4'd3: begin
            enc_word    = {4'b0110, FieldA[2:0], 2'b00};
            enc_illegal = FieldA[3];
         end
         4'd4: begin
            enc_word    = {4'b0111, FieldA[2:0], 2'b00};
            enc_illegal = FieldA[3];
         end
         4'd5: begin
            enc_word    = {4'b1110, FieldA[2:0], 2'b00};
            enc_illegal = FieldA[3];
         end
         4'd6: begin
            enc_word    = {4'b1110, FieldA[2:0], 2'b10};
            enc_illegal = FieldA[3];
         end
         4'd7: begin
            // Imm=31 would encode exactly as the Ack terminator.
            enc_word    = {4'b1111, Imm};
            enc_illegal = (Imm == 5'd31);
         end
         4'd8:  enc_word = {4'b1000, 1'b0, FieldB[1:0], 2'b00};
         4'd9:  enc_word = {4'b1000, 1'b1, FieldB[1:0], 2'b00};
         4'd10: enc_word = {4'b1001, FieldB[1:0], Flag, 2'b00};
         4'd11: begin
            enc_word    = {4'b1010, FieldA[2:0], Flag, 1'b0};
            enc_illegal = FieldA[3];
         end
         4'd12: begin
            enc_word    = {5'b01000, FieldA[2:0], 1'b0};
            enc_illegal = FieldA[3];
         end
         4'd13: begin
            enc_word    = {5'b01001, FieldA[2:0], 1'b0};
            enc_illegal = FieldA[3];
         end
         4'd14: begin
            enc_word    = {4'b1100, FieldA[2:0], 2'b00};
            enc_illegal = FieldA[3];
         end
         default: begin
            case (FieldA[1:0])
               2'd0:    enc_word = {6'b101100, FieldB[1:0], 1'b0};
               2'd1:    enc_word = {6'b101101, FieldB[1:0], 1'b0};
               2'd2:    enc_word = {6'b101110, FieldB[1:0], 1'b0};
               default: enc_illegal = 1'b1;
            endcase
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      count_d   = count_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = done_q;
      error_d   = error_q;
      case (state_q)
         ST_RUN: begin
            if (xfer) begin
               if (enc_illegal) begin
                  error_d = 1'b1;
                  if (Last) state_d = ST_TERM;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = enc_word;
                  addr_d    = addr_q + ADDR_ONE;
                  count_d   = count_q + CNT_ONE;
                  if (Last) begin
                     state_d = ST_TERM;
                  end else if (addr_q == LAST_DATA_ADDR) begin
                     state_d = ST_TERM;
                     error_d = 1'b1;
                  end
               end
            end
         end
         ST_TERM: begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = ACK_WORD;
            count_d   = count_q + CNT_ONE;
            state_d   = ST_DONE;
         end
         ST_DONE: done_d = 1'b1;
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q   <= ST_RUN;
         addr_q    <= '0;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder (ADDR_W=3): scoreboard queue of expected
// {address, word} writes checked by an independent write monitor.
module tb_inst_encoder;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int W      = ADDR_W + 9;

   logic              Clk = 1'b0;
   logic              Reset = 1'b0;
   logic              InValid = 1'b0;
   logic              InReady;
   logic [3:0]        Mnemonic = '0;
   logic [3:0]        FieldA = '0;
   logic [3:0]        FieldB = '0;
   logic [4:0]        Imm = '0;
   logic              Flag = 1'b0;
   logic              Last = 1'b0;
   logic              WrEn;
   logic [ADDR_W-1:0] WrAddr;
   logic [8:0]        WrData;
   logic              Done;
   logic              Error;
   logic [ADDR_W:0]   Count;
   logic [1:0]        DbgState;

   always #5 Clk = ~Clk;

   inst_encoder #(.ADDR_W(ADDR_W)) dut (
      .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .Mnemonic(Mnemonic), .FieldA(FieldA), .FieldB(FieldB), .Imm(Imm),
      .Flag(Flag), .Last(Last), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
      .Done(Done), .Error(Error), .Count(Count), .DbgState(DbgState)
   );

   logic [W-1:0] exp_q[$];
   int           n_vec = 0;
   int           n_err = 0;
   int           exp_addr = 0;
   int           exp_words = 0;
   logic         exp_err = 1'b0;

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Write monitor: every WrEn pulse must match the oldest expected write.
   always @(negedge Clk) begin
      if (WrEn === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_write: got addr %0d data 0x%0h, expected no write", WrAddr, WrData);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("wr_addr", int'(WrAddr), int'(e[W-1:9]));
            check("wr_data", int'(WrData), int'(e[8:0]));
         end
      end
   end

   task automatic do_reset();
      Reset = 1'b0;
      InValid = 1'b0;
      Last = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check("queue_drained_before_reset", exp_q.size(), 0);
      exp_q.delete();
      check("rst_in_ready", InReady, 1);
      check("rst_wr_en", WrEn, 0);
      check("rst_wr_addr", WrAddr, 0);
      check("rst_wr_data", WrData, 0);
      check("rst_done", Done, 0);
      check("rst_error", Error, 0);
      check("rst_count", Count, 0);
      check("rst_state", DbgState, 0);
      Reset = 1'b1;
      exp_addr = 0;
      exp_words = 0;
      exp_err = 1'b0;
   endtask

   task automatic idle(input int n);
      InValid = 1'b0;
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic send(input logic [3:0] m, input logic [3:0] a, input logic [3:0] b,
                       input logic [4:0] imm, input logic flg, input logic lst,
                       input logic legal, input logic [8:0] word);
      logic term;
      Mnemonic = m; FieldA = a; FieldB = b; Imm = imm; Flag = flg; Last = lst;
      InValid = 1'b1;
      check("in_ready_before_xfer", InReady, 1);
      term = lst;
      if (legal) begin
         exp_q.push_back({exp_addr[ADDR_W-1:0], word});
         exp_addr++;
         exp_words++;
         if (!lst && exp_addr == DEPTH - 1) begin
            term = 1'b1;
            exp_err = 1'b1;
         end
      end else begin
         exp_err = 1'b1;
      end
      if (term) exp_q.push_back({exp_addr[ADDR_W-1:0], 9'h1FF});
      @(posedge Clk);
      #1;
      InValid = 1'b0;
      Last = 1'b0;
      check("count_after_xfer", Count, exp_words);
      check("error_after_xfer", Error, exp_err);
   endtask

   task automatic finish_prog(input int exp_count, input logic exp_error);
      int k;
      k = 0;
      while (Done !== 1'b1 && k < 10) begin
         @(posedge Clk);
         #1;
         k++;
      end
      check("done", Done, 1);
      check("final_count", Count, exp_count);
      check("final_error", Error, exp_error);
      check("in_ready_when_done", InReady, 0);
      repeat (3) @(posedge Clk);
      #1;
      check("done_held", Done, 1);
      check("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Basic program with exact Done timing.
      do_reset();
      send(4'd0, 4'd2, 4'd5, 5'd0, 1'b0, 1'b0, 1'b1, 9'h015);
      send(4'd7, 4'd0, 4'd0, 5'd3, 1'b0, 1'b1, 1'b1, 9'h1E3);
      check("t1_in_ready_low", InReady, 0);
      check("t1_done_n1", Done, 0);
      @(posedge Clk); #1;
      check("t1_done_n2", Done, 0);
      @(posedge Clk); #1;
      check("t1_done_n3", Done, 1);
      finish_prog(3, 1'b0);

      // Every opcode, back to back, in three programs.
      do_reset();
      send(4'd0,  4'd3, 4'd6, 5'd0,  1'b0, 1'b0, 1'b1, 9'h01E);
      send(4'd1,  4'd7, 4'd1, 5'd0,  1'b0, 1'b0, 1'b1, 9'h079);
      send(4'd2,  4'd4, 4'd6, 5'd0,  1'b0, 1'b0, 1'b1, 9'h1B2);
      send(4'd3,  4'd5, 4'd0, 5'd0,  1'b0, 1'b0, 1'b1, 9'h0D4);
      send(4'd4,  4'd1, 4'd0, 5'd0,  1'b0, 1'b0, 1'b1, 9'h0E4);
      send(4'd5,  4'd6, 4'd0, 5'd0,  1'b0, 1'b1, 1'b1, 9'h1D8);
      finish_prog(7, 1'b0);
      do_reset();
      send(4'd6,  4'd2, 4'd0, 5'd0,  1'b0, 1'b0, 1'b1, 9'h1CA);
      send(4'd7,  4'd0, 4'd0, 5'd30, 1'b0, 1'b0, 1'b1, 9'h1FE);
      send(4'd8,  4'd0, 4'd3, 5'd0,  1'b0, 1'b0, 1'b1, 9'h10C);
      send(4'd9,  4'd0, 4'd1, 5'd0,  1'b0, 1'b0, 1'b1, 9'h114);
      send(4'd10, 4'd0, 4'd2, 5'd0,  1'b1, 1'b0, 1'b1, 9'h134);
      send(4'd11, 4'd5, 4'd0, 5'd0,  1'b1, 1'b1, 1'b1, 9'h156);
      finish_prog(7, 1'b0);
      do_reset();
      send(4'd12, 4'd3, 4'd0, 5'd0,  1'b0, 1'b0, 1'b1, 9'h086);
      send(4'd13, 4'd6, 4'd0, 5'd0,  1'b0, 1'b0, 1'b1, 9'h09C);
      send(4'd14, 4'd7, 4'd0, 5'd0,  1'b0, 1'b0, 1'b1, 9'h19C);
      send(4'd15, 4'd0, 4'd2, 5'd0,  1'b0, 1'b0, 1'b1, 9'h164);
      send(4'd15, 4'd1, 4'd3, 5'd0,  1'b0, 1'b0, 1'b1, 9'h16E);
      send(4'd15, 4'd2, 4'd1, 5'd0,  1'b0, 1'b1, 1'b1, 9'h172);
      finish_prog(7, 1'b0);

      // Illegal instructions are dropped; next legal word keeps the address.
      do_reset();
      send(4'd0,  4'd2, 4'd5, 5'd0,  1'b0, 1'b0, 1'b1, 9'h015);
      send(4'd7,  4'd0, 4'd0, 5'd31, 1'b0, 1'b0, 1'b0, 9'h000);
      send(4'd2,  4'd1, 4'd2, 5'd0,  1'b0, 1'b0, 1'b0, 9'h000);
      send(4'd5,  4'd9, 4'd0, 5'd0,  1'b0, 1'b0, 1'b0, 9'h000);
      send(4'd15, 4'd3, 4'd0, 5'd0,  1'b0, 1'b0, 1'b0, 9'h000);
      send(4'd3,  4'd5, 4'd0, 5'd0,  1'b0, 1'b1, 1'b1, 9'h0D4);
      finish_prog(3, 1'b1);

      // Overflow: seven words fill 0..6, terminator forced into slot 7.
      do_reset();
      send(4'd0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 9'h000);
      send(4'd0, 4'd1, 4'd1, 5'd0, 1'b0, 1'b0, 1'b1, 9'h009);
      send(4'd0, 4'd2, 4'd2, 5'd0, 1'b0, 1'b0, 1'b1, 9'h012);
      send(4'd0, 4'd3, 4'd3, 5'd0, 1'b0, 1'b0, 1'b1, 9'h01B);
      send(4'd0, 4'd4, 4'd4, 5'd0, 1'b0, 1'b0, 1'b1, 9'h024);
      send(4'd0, 4'd5, 4'd5, 5'd0, 1'b0, 1'b0, 1'b1, 9'h02D);
      send(4'd0, 4'd6, 4'd6, 5'd0, 1'b0, 1'b0, 1'b1, 9'h036);
      check("ovf_in_ready_low", InReady, 0);
      finish_prog(8, 1'b1);

      // Reset mid-stream, then a fresh program from address 0.
      do_reset();
      send(4'd7, 4'd0, 4'd0, 5'd31, 1'b0, 1'b0, 1'b0, 9'h000);
      send(4'd0, 4'd2, 4'd5, 5'd0,  1'b0, 1'b0, 1'b1, 9'h015);
      send(4'd1, 4'd7, 4'd1, 5'd0,  1'b0, 1'b0, 1'b1, 9'h079);
      do_reset();
      send(4'd3, 4'd5, 4'd0, 5'd0,  1'b0, 1'b1, 1'b1, 9'h0D4);
      finish_prog(2, 1'b0);

      // Random idle gaps, then illegal+Last writes only the terminator.
      do_reset();
      idle($urandom_range(1, 5));
      send(4'd8, 4'd0, 4'd3, 5'd0,  1'b0, 1'b0, 1'b1, 9'h10C);
      idle($urandom_range(1, 5));
      send(4'd10, 4'd0, 4'd2, 5'd0, 1'b1, 1'b0, 1'b1, 9'h134);
      idle($urandom_range(1, 5));
      send(4'd7, 4'd0, 4'd0, 5'd31, 1'b0, 1'b1, 1'b0, 9'h000);
      finish_prog(3, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
